// File: rtl/axi2ahb_burst_arbiter_pkg.sv
// Shared types and helpers for the AXI-to-AHB burst arbiter.
// Holds the arbiter state encoding and the req_len slice offset helper.
package axi2ahb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int LEN_W_DEF = 8;

    // LSB position of requester idx's length field in the flattened req_len bus.
    function automatic int len_lsb(input int idx, input int len_w);
        return idx * len_w;
    endfunction

endpackage

// File: rtl/axi2ahb_burst_arbiter_if.sv
// Request/grant bundle between the AXI-side requesters and the burst arbiter.
// The slave modport is the arbiter; the master modport is the bridge/requester side.
interface axi2ahb_burst_arbiter_if
    import axi2ahb_pkg::*;
#(
    parameter int N     = 4,
    parameter int LEN_W = LEN_W_DEF
);
    localparam int ID_W = $clog2(N);

    logic [N-1:0]       req;
    logic [N*LEN_W-1:0] req_len;
    logic [N-1:0]       req_lock;
    logic               beat_done;
    logic [N-1:0]       grant;
    logic               gnt_valid;
    logic [ID_W-1:0]    gnt_id;
    logic               last_beat;
    logic [LEN_W-1:0]   beat_cnt;

    modport slave (
        input  req, req_len, req_lock, beat_done,
        output grant, gnt_valid, gnt_id, last_beat, beat_cnt
    );

    modport master (
        output req, req_len, req_lock, beat_done,
        input  grant, gnt_valid, gnt_id, last_beat, beat_cnt
    );

endinterface

// File: rtl/axi2ahb_burst_arbiter_rr_pick.sv
// Combinational round-robin chooser: first set request at or above the one-hot
// pointer wins, otherwise the lowest set request below it.
module rr_pick
    import axi2ahb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    request,
    input  logic [N-1:0]    ptr,
    output logic [N-1:0]    pick,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [N-1:0] upper;
    logic [N-1:0] cand;

    always_comb begin
        // ptr is one-hot, so ptr-1 masks exactly the requesters below it.
        upper = request & ~(ptr - N'(1));
        cand  = (upper != '0) ? upper : request;
        pick  = cand & (~cand + N'(1));
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (pick[i]) idx = ID_W'(i);
        end
        any   = |request;
    end

endmodule

// File: rtl/axi2ahb_burst_arbiter.sv
// Round-robin arbiter for the bridge's single AHB master port; holds the grant
// for a whole burst by counting accepted beats, and re-grants a locked owner without a bubble.
module axi2ahb_burst_arbiter
    import axi2ahb_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int LEN_W   = LEN_W_DEF,
    parameter  int PRI_RST = 0,
    localparam int ID_W    = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    axi2ahb_burst_arbiter_if.slave  bus
);

    arb_state_t       state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     ptr_q, ptr_d;

    logic [N-1:0]     pick;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic [LEN_W-1:0] pick_len;
    logic [LEN_W-1:0] own_len;
    logic             lock_hold;

    rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
        .request (bus.req),
        .ptr     (ptr_q),
        .pick    (pick),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    assign pick_len  = bus.req_len[len_lsb(int'(pick_idx), LEN_W) +: LEN_W];
    assign own_len   = bus.req_len[len_lsb(int'(id_q), LEN_W) +: LEN_W];
    assign lock_hold = bus.req_lock[id_q] & bus.req[id_q];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= N'(1) << PRI_RST;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = OWN;
                    grant_d = pick;
                    id_d    = pick_idx;
                    cnt_d   = pick_len;
                end
            end
            OWN: begin
                if (bus.beat_done) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end else if (lock_hold) begin
                        cnt_d = own_len;
                    end else begin
                        // Release always passes through IDLE so the AHB mux sees a clean gap.
                        ptr_d   = {grant_q[N-2:0], grant_q[N-1]};
                        state_d = IDLE;
                        grant_d = '0;
                        id_d    = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.grant     = grant_q;
    assign bus.gnt_valid = |grant_q;
    assign bus.gnt_id    = id_q;
    assign bus.beat_cnt  = cnt_q;
    assign bus.last_beat = (|grant_q) & (cnt_q == '0);

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(grant_q));
    a_no_beat_idle: assert property (@(posedge clk) disable iff (!rst)
        (state_q == IDLE) |-> !bus.beat_done);
    a_owner_holds_req: assert property (@(posedge clk) disable iff (!rst)
        (state_q == OWN) |-> bus.req[id_q]);

endmodule

// File: tb/tb_axi2ahb_burst_arbiter.sv
// Directed bench for axi2ahb_burst_arbiter (N=4, LEN_W=8, PRI_RST=0).
module tb_axi2ahb_burst_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    axi2ahb_burst_arbiter_if #(.N(4), .LEN_W(8)) bus ();

    axi2ahb_burst_arbiter #(.N(4), .LEN_W(8), .PRI_RST(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_len(input int i, input logic [7:0] v);
        bus.req_len[i*8 +: 8] = v;
    endtask

    logic [3:0] rr_exp [0:8];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.req = 4'b0110;
        bus.req_len = '0;
        bus.req_lock = '0;
        bus.beat_done = 1'b1;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0000; rr_exp[2] = 4'b0010;
        rr_exp[3] = 4'b0000; rr_exp[4] = 4'b0100; rr_exp[5] = 4'b0000;
        rr_exp[6] = 4'b1000; rr_exp[7] = 4'b0000; rr_exp[8] = 4'b0001;

        // Reset with requests and beat_done active: nothing may be granted.
        tick(); tick(); tick();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_valid", 32'(bus.gnt_valid), 32'h0);
        chk("rst_id", 32'(bus.gnt_id), 32'h0);
        chk("rst_cnt", 32'(bus.beat_cnt), 32'h0);
        chk("rst_last", 32'(bus.last_beat), 32'h0);

        // Basic grant: req=0110, len[1]=3.
        set_len(1, 8'd3);
        rst = 1'b1;
        bus.beat_done = 1'b0;
        tick();
        chk("t1_grant", 32'(bus.grant), 32'h2);
        chk("t1_id", 32'(bus.gnt_id), 32'h1);
        chk("t1_cnt", 32'(bus.beat_cnt), 32'h3);
        chk("t1_last0", 32'(bus.last_beat), 32'h0);
        bus.beat_done = 1'b1;
        tick();
        chk("t1_cnt2", 32'(bus.beat_cnt), 32'h2);
        tick();
        tick();
        chk("t1_cnt0", 32'(bus.beat_cnt), 32'h0);
        chk("t1_last4", 32'(bus.last_beat), 32'h1);
        chk("t1_hold", 32'(bus.grant), 32'h2);
        tick();
        bus.beat_done = 1'b0;
        chk("t1_release", 32'(bus.grant), 32'h0);
        chk("t1_rel_valid", 32'(bus.gnt_valid), 32'h0);
        tick();
        chk("t1_next_grant", 32'(bus.grant), 32'h4);
        chk("t1_next_id", 32'(bus.gnt_id), 32'h2);
        bus.beat_done = 1'b1;
        tick();
        bus.beat_done = 1'b0;
        bus.req = 4'b0000;
        chk("t1_rel2", 32'(bus.grant), 32'h0);
        tick();

        // Round robin from pointer 0 with single-beat bursts.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.req_len = '0;
        for (int c = 0; c < 9; c++) begin
            tick();
            chk($sformatf("rr_grant_%0d", c), 32'(bus.grant), 32'(rr_exp[c]));
            bus.beat_done = bus.gnt_valid;
        end
        tick();
        bus.beat_done = 1'b0;
        bus.req = 4'b0000;
        chk("rr_end", 32'(bus.grant), 32'h0);

        // Pointer wrap: move pointer to 3 via owner 2, then owner 3 releases.
        bus.req = 4'b0100;
        tick();
        chk("wr_g2", 32'(bus.grant), 32'h4);
        bus.beat_done = 1'b1;
        tick();
        bus.beat_done = 1'b0;
        bus.req = 4'b1001;
        tick();
        chk("wr_g3", 32'(bus.grant), 32'h8);
        chk("wr_id3", 32'(bus.gnt_id), 32'h3);
        bus.beat_done = 1'b1;
        tick();
        bus.beat_done = 1'b0;
        chk("wr_gap", 32'(bus.grant), 32'h0);
        tick();
        chk("wr_g0", 32'(bus.grant), 32'h1);
        chk("wr_id0", 32'(bus.gnt_id), 32'h0);
        bus.beat_done = 1'b1;
        tick();
        bus.beat_done = 1'b0;
        bus.req = 4'b0000;
        tick();

        // Locked owner 2, len=1: re-granted without a bubble, then released.
        bus.req = 4'b0100;
        bus.req_lock = 4'b0100;
        set_len(2, 8'd1);
        tick();
        chk("lk_grant", 32'(bus.grant), 32'h4);
        chk("lk_cnt1", 32'(bus.beat_cnt), 32'h1);
        bus.beat_done = 1'b1;
        tick();
        chk("lk_last", 32'(bus.last_beat), 32'h1);
        tick();
        chk("lk_keep", 32'(bus.grant), 32'h4);
        chk("lk_reload", 32'(bus.beat_cnt), 32'h1);
        bus.req_lock = 4'b0000;
        tick();
        chk("lk_cnt0", 32'(bus.beat_cnt), 32'h0);
        tick();
        bus.beat_done = 1'b0;
        chk("lk_release", 32'(bus.grant), 32'h0);
        bus.req = 4'b1001;
        tick();
        chk("lk_ptr3", 32'(bus.grant), 32'h8);
        bus.beat_done = 1'b1;
        tick();
        bus.beat_done = 1'b0;
        bus.req = 4'b0000;
        tick();

        // Maximum burst: len=FF gives 256 beats.
        bus.req = 4'b0001;
        set_len(0, 8'hFF);
        tick();
        chk("mx_grant", 32'(bus.grant), 32'h1);
        chk("mx_cnt255", 32'(bus.beat_cnt), 32'd255);
        bus.beat_done = 1'b1;
        for (int k = 254; k >= 0; k--) begin
            tick();
            chk($sformatf("mx_cnt_%0d", k), 32'(bus.beat_cnt), 32'(k));
        end
        chk("mx_hold", 32'(bus.grant), 32'h1);
        chk("mx_last", 32'(bus.last_beat), 32'h1);
        tick();
        bus.beat_done = 1'b0;
        bus.req = 4'b0000;
        chk("mx_release", 32'(bus.grant), 32'h0);
        tick();

        // Reset mid-burst with beat_cnt=5.
        set_len(0, 8'h00);
        set_len(1, 8'd5);
        bus.req = 4'b0010;
        tick();
        chk("rm_grant", 32'(bus.grant), 32'h2);
        chk("rm_cnt5", 32'(bus.beat_cnt), 32'd5);
        rst = 1'b0;
        bus.beat_done = 1'b1;
        tick();
        chk("rm_grant0", 32'(bus.grant), 32'h0);
        chk("rm_cnt0", 32'(bus.beat_cnt), 32'h0);
        chk("rm_id0", 32'(bus.gnt_id), 32'h0);
        tick();
        chk("rm_still0", 32'(bus.grant), 32'h0);
        rst = 1'b1;
        bus.beat_done = 1'b0;
        bus.req = 4'b0101;
        tick();
        chk("rm_ptr_rst", 32'(bus.grant), 32'h1);
        bus.beat_done = 1'b1;
        tick();
        bus.beat_done = 1'b0;
        bus.req = 4'b0000;
        chk("rm_end", 32'(bus.grant), 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi2ahb_burst_arbiter.md
Name: axi2ahb_burst_arbiter

Overview:
- Shares the single AHB master port of the AXI-to-AHB bridge between N AXI-side requesters (read and write channels, or several AXI slave ports).
- Picks one requester by round-robin and holds its grant for a whole burst by counting accepted AHB beats.
- Releases the grant on the last beat, or keeps it for the next burst when the owner asserts lock.
- The bridge datapath mux uses gnt_id to select the owner's address/control onto the AHB side.

Parameters:
N, 4, number of requesters (2..16)
LEN_W, 8, width of the burst length field (AXI AxLEN: beats = len+1)
PRI_RST, 0, requester holding highest priority after reset (0..N-1)
ID_W, $clog2(N), width of gnt_id (derived, do not override)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
req  in  N  per-requester burst request; held high until that requester's last beat is accepted
req_len  in  N*LEN_W  per-requester AxLEN; slice i = bits [i*LEN_W +: LEN_W]; sampled at grant
req_lock  in  N  per-requester lock; sampled on owner's last beat
beat_done  in  1  AHB data-phase beat accepted (HREADY & active transfer) for the current owner
grant  out  N  registered one-hot grant, all-zero when idle
gnt_valid  out  1  OR of grant
gnt_id  out  ID_W  binary index of owner, 0 when idle
last_beat  out  1  combinational: gnt_valid & (beat_cnt == 0)
beat_cnt  out  LEN_W  beats remaining after the current one

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, grant=0, gnt_valid=0, gnt_id=0, beat_cnt=0.
  - Priority pointer = PRI_RST.
  - Reset mid-burst aborts at once; the bridge flushes in the same reset.
- Arbitration:
  - Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1; the first set req bit wins.
  - The search is purely combinational on req and the pointer.
- FSM states: IDLE, OWN.
- IDLE:
  - If any req bit is set, next cycle: grant = one-hot winner, gnt_id = winner, beat_cnt = req_len[winner], state = OWN.
  - Latency from req to grant is exactly 1 cycle.
  - If no req, stay IDLE.
  - beat_done in IDLE is ignored and flagged by assertion.
- OWN, beat_done=0: hold everything.
- OWN, beat_done=1, beat_cnt!=0: beat_cnt decrements by 1.
- OWN, beat_done=1, beat_cnt==0 (last beat):
  - If req_lock[owner] & req[owner]: stay OWN, reload beat_cnt = req_len[owner]. The pointer is unchanged and there is no bubble.
  - Otherwise: pointer = owner+1 (N-1 wraps to 0), grant cleared next cycle, state = IDLE.
  - This gives a guaranteed one idle cycle between different owners, so the AHB mux switches cleanly.
- req and req_len changes from non-owners during OWN are ignored.
- Owner dropping req before its last beat is a protocol violation: the grant is held anyway, plus an assertion.
- len = 2^LEN_W-1 gives 2^LEN_W beats. The counter never underflows because it only decrements when non-zero.
- The pointer only advances on a released burst, so a locked owner can starve others. This is intended: it matches AXI locked access.
- grant must be one-hot or zero at all times (assertion).

Decomposition:
- Shared package axi2ahb_pkg holds:
  - arb_state_t enum {IDLE, OWN}.
  - Defaults for LEN_W and the per-slice req_len extraction helper.
- Sub-module rr_pick: combinational round-robin chooser.
  - Inputs: request[N] and a one-hot pointer.
  - Outputs: one-hot pick, binary index, any.
- The top holds the FSM, pointer register, beat counter and grant registers.

Test Plan:
- Reset then req=4'b0110, PRI_RST=0, len[1]=3 -> grant=0010 one cycle later, gnt_id=1. After 4 beat_done, last_beat high on the 4th; grant=0 next cycle. Then requester 2 is granted 1 cycle after that (pointer=2).
- All req=1111, all len=0, no lock, beat_done every owned cycle -> grant order 0,1,2,3,0; each grant lasts 1 cycle with 1 idle cycle between.
- Owner 3 on its last beat with the pointer at 3 -> pointer wraps to 0; with req=1001, requester 0 is granted next.
- Owner 2 with req_lock[2]=1 and req[2]=1 at last beat, len=1 -> grant stays 0100 with no bubble and beat_cnt reloads to 1. Lock dropped on the next last beat -> release and pointer=3.
- len=8'hFF -> exactly 256 beat_done before release; beat_cnt steps 255..0.
- rst low during OWN with beat_cnt=5 -> next cycle grant=0, state IDLE, pointer=PRI_RST. beat_done during reset/IDLE causes no grant.
